// File: rtl/mod_enc_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mod_enc_round_ctrl
// Description : AES-256 round sequencer issuing one-hot stage strobes and
//               the AddRoundKey source / round-key index. Optional block
//               counter enabled by defining AES_CTRL_BLKCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_enc_round_ctrl #(
  parameter int NR = 14,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          key_ready,
  output logic          en_sb,
  output logic          en_sr,
  output logic          en_mc,
  output logic          en_ark,
  output logic [1:0]    ark_src,
  output logic [RW-1:0] round_idx,
  output logic          busy,
  output logic          out_valid,
`ifdef AES_CTRL_BLKCNT_EN
  output logic [31:0]   blk_cnt,
`endif
  input  logic          out_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARK0 = 3'd1,
    S_SB   = 3'd2,
    S_SR   = 3'd3,
    S_MC   = 3'd4,
    S_ARK  = 3'd5,
    S_DONE = 3'd6
  } state_e;

  localparam logic [RW-1:0] LAST_ROUND = RW'(NR);
  localparam logic [1:0]    SRC_PT     = 2'b00;
  localparam logic [1:0]    SRC_MC     = 2'b01;
  localparam logic [1:0]    SRC_SR     = 2'b10;

  state_e        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [1:0]    src_q, src_d;
  logic [RW-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      src_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    src_d   = src_q;
    idx_d   = idx_q;
    en_sb   = 1'b0;
    en_sr   = 1'b0;
    en_mc   = 1'b0;
    en_ark  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) state_d = S_ARK0;
      end
      S_ARK0: begin
        en_ark  = 1'b1;
        src_d   = SRC_PT;
        idx_d   = '0;
        round_d = RW'(1);
        state_d = S_SB;
      end
      S_SB: begin
        en_sb   = 1'b1;
        state_d = S_SR;
      end
      S_SR: begin
        en_sr   = 1'b1;
        // Final round skips MixColumns and keys straight off ShiftRows.
        state_d = (round_q == LAST_ROUND) ? S_ARK : S_MC;
      end
      S_MC: begin
        en_mc   = 1'b1;
        state_d = S_ARK;
      end
      S_ARK: begin
        en_ark = 1'b1;
        idx_d  = round_q;
        if (round_q == LAST_ROUND) begin
          src_d   = SRC_SR;
          state_d = S_DONE;
        end else begin
          src_d   = SRC_MC;
          round_d = round_q + RW'(1);
          state_d = S_SB;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Held registers pass straight through outside ARK states, so the
  // next-state values double as the qualified outputs.
  assign ark_src   = src_d;
  assign round_idx = idx_d;
  assign in_ready  = (state_q == S_IDLE) && key_ready;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);

`ifdef AES_CTRL_BLKCNT_EN
  logic [31:0] blk_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      blk_cnt_q <= blk_cnt_q + 32'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_enc_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_enc_round_ctrl
// Description : Scoreboard bench for the AES-256 round sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_enc_round_ctrl;

  localparam int NR     = 14;
  localparam int RW     = 4;
  localparam int NSTROB = 4 * NR;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          key_ready = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          en_sb, en_sr, en_mc, en_ark;
  logic [1:0]    ark_src;
  logic [RW-1:0] round_idx;
  logic          busy, out_valid;
`ifdef AES_CTRL_BLKCNT_EN
  logic [31:0]   blk_cnt;
`endif

  mod_enc_round_ctrl #(.NR(NR), .RW(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_ready (key_ready),
    .en_sb     (en_sb),
    .en_sr     (en_sr),
    .en_mc     (en_mc),
    .en_ark    (en_ark),
    .ark_src   (ark_src),
    .round_idx (round_idx),
    .busy      (busy),
    .out_valid (out_valid),
`ifdef AES_CTRL_BLKCNT_EN
    .blk_cnt   (blk_cnt),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Expected strobe event: {ark, sb, sr, mc} plus key operand for ARK events
  typedef struct packed {
    logic [3:0]    str;
    logic [1:0]    src;
    logic [RW-1:0] idx;
  } exp_t;

  exp_t          q_exp[$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            mon_en = 1'b0;

  // Abstract model: 0 = idle, 1 = issuing strobes, 2 = holding result
  int            m_st = 0;
  int            m_cnt = 0;
  logic [1:0]    m_src = '0;
  logic [RW-1:0] m_idx = '0;
  logic [31:0]   m_blk = '0;

  function automatic void push_block();
    exp_t e;
    for (int k = 1; k <= NSTROB; k++) begin
      e = '0;
      if (k == 1) begin
        e.str = 4'b1000; e.src = 2'b00; e.idx = '0;
      end else if (k > NSTROB - 3) begin
        case (k - (NSTROB - 2))
          0:       e.str = 4'b0100;
          1:       e.str = 4'b0010;
          default: begin e.str = 4'b1000; e.src = 2'b10; e.idx = RW'(NR); end
        endcase
      end else begin
        case ((k - 2) % 4)
          0:       e.str = 4'b0100;
          1:       e.str = 4'b0010;
          2:       e.str = 4'b0001;
          default: begin e.str = 4'b1000; e.src = 2'b01; e.idx = RW'((k - 2) / 4 + 1); end
        endcase
      end
      q_exp.push_back(e);
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0;
      m_cnt = 0;
      q_exp.delete();
      m_src = '0;
      m_idx = '0;
      m_blk = '0;
    end else begin
      case (m_st)
        0: if (in_valid && key_ready) begin
             m_st = 1;
             m_cnt = NSTROB;
             push_block();
           end
        1: begin
             m_cnt--;
             if (m_cnt == 0) m_st = 2;
           end
        default: if (out_ready) begin
             m_st = 0;
             m_blk = m_blk + 32'd1;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [3:0] str;
    logic [3:0] ctl_act, ctl_exp;
    exp_t       e;
    if (mon_en) begin
      str = {en_ark, en_sb, en_sr, en_mc};
      ctl_act = {in_ready, busy, out_valid, (str != 4'b0000)};
      ctl_exp = {(m_st == 0) && key_ready, m_st != 0, m_st == 2, m_st == 1};
      n_cmp++;
      if (ctl_act !== ctl_exp) begin
        n_err++;
        $display("FAIL ctrl t=%0t {in_ready,busy,out_valid,strobe} got %b want %b", $time, ctl_act, ctl_exp);
      end
      if (str != 4'b0000) begin
        n_cmp++;
        if (q_exp.size() == 0) begin
          n_err++;
          $display("FAIL strobe t=%0t unexpected strobes %b with empty scoreboard", $time, str);
        end else begin
          e = q_exp.pop_front();
          if (str !== e.str || (e.str[3] && {ark_src, round_idx} !== {e.src, e.idx})) begin
            n_err++;
            $display("FAIL strobe t=%0t got str=%b src=%b idx=%0d want str=%b src=%b idx=%0d",
                     $time, str, ark_src, round_idx, e.str, e.src, e.idx);
          end
          if (e.str[3]) begin
            m_src = e.src;
            m_idx = e.idx;
          end
        end
      end
      if (!en_ark) begin
        n_cmp++;
        if ({ark_src, round_idx} !== {m_src, m_idx}) begin
          n_err++;
          $display("FAIL hold t=%0t got src=%b idx=%0d want src=%b idx=%0d",
                   $time, ark_src, round_idx, m_src, m_idx);
        end
      end
`ifdef AES_CTRL_BLKCNT_EN
      n_cmp++;
      if (blk_cnt !== m_blk) begin
        n_err++;
        $display("FAIL blk_cnt t=%0t got %0d want %0d", $time, blk_cnt, m_blk);
      end
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk) #1;
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    int c = 0;
    while (m_st != st && c < budget) begin
      step(1);
      c++;
    end
    n_cmp++;
    if (m_st != st) begin
      n_err++;
      $display("FAIL timeout %s got state %0d want %0d", tag, m_st, st);
    end
  endtask

  initial begin
    step(1);
    mon_en = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);

    // Single block with free-running handshakes
    key_ready = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    wait_state(0, 100, "single");
    step(2);

    // Key schedule not ready: request must wait
    key_ready = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step(10);
    key_ready = 1'b1;
    step(1);
    in_valid = 1'b0;
    key_ready = 1'b0;
    wait_state(2, 100, "keywait");

    // Consumer stall, then back-to-back accept
    key_ready = 1'b1;
    step(20);
    out_ready = 1'b1; in_valid = 1'b1;
    wait_state(1, 5, "b2b");
    in_valid = 1'b0;
    wait_state(0, 100, "b2b_done");

    // Reset in round 7 MixColumns, then a fresh block
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    begin
      int c = 0;
      while (!(m_st == 1 && m_cnt == NSTROB - 27) && c < 100) begin
        step(1);
        c++;
      end
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    wait_state(0, 100, "after_rst");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      key_ready = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 1'b0; in_valid = 1'b0; key_ready = 1'b1; out_ready = 1'b1;
    wait_state(0, 100, "drain");
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
